// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - instruction fields, memory handshake and datapath strobes of the multicycle controller
interface multicycle_control_fsm_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [3:0] Flags;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Flags
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Flags
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle ARM-subset controller with NZCV flags and condition evaluation
// Optional MCFSM_CMP_EN: decode cmd 1010 as CMP (subtract, flags only).
module multicycle_control_fsm (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state, state_nx;
  logic       cond_ok;
  logic       cond_ex;
  logic [3:0] flags;
  logic [3:0] cmd;
  logic       dp_valid, dp_wr, dp_arith;
  logic [1:0] dp_alu;
  logic       rd_pc;
  logic       pc_w, ir_w, reg_w, mem_w;
  logic       flag_upd;

  assign cmd   = bus.Funct[4:1];
  assign rd_pc = (bus.Rd == 4'hF);

  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'h0: cond_ex = flags[2];
      4'h1: cond_ex = ~flags[2];
      4'h2: cond_ex = flags[1];
      4'h3: cond_ex = ~flags[1];
      4'h4: cond_ex = flags[3];
      4'h5: cond_ex = ~flags[3];
      4'h6: cond_ex = flags[0];
      4'h7: cond_ex = ~flags[0];
      4'h8: cond_ex = flags[1] & ~flags[2];
      4'h9: cond_ex = ~flags[1] | flags[2];
      4'hA: cond_ex = (flags[3] == flags[0]);
      4'hB: cond_ex = (flags[3] != flags[0]);
      4'hC: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'hD: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // dp_wr separates commands that produce a result from flag-only ones and NOPs
  always_comb begin
    dp_valid = 1'b0;
    dp_wr    = 1'b0;
    dp_arith = 1'b0;
    dp_alu   = 2'b00;
    case (cmd)
      4'b0100: begin dp_valid = 1'b1; dp_wr = 1'b1; dp_arith = 1'b1; dp_alu = 2'b00; end
      4'b0010: begin dp_valid = 1'b1; dp_wr = 1'b1; dp_arith = 1'b1; dp_alu = 2'b01; end
      4'b0000: begin dp_valid = 1'b1; dp_wr = 1'b1; dp_alu = 2'b10; end
      4'b1100: begin dp_valid = 1'b1; dp_wr = 1'b1; dp_alu = 2'b11; end
`ifdef MCFSM_CMP_EN
      4'b1010: begin dp_valid = 1'b1; dp_arith = 1'b1; dp_alu = 2'b01; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      cond_ok <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == DECODE) cond_ok <= cond_ex;
    end
  end

  assign flag_upd = (state == EXECR || state == EXECI) && cond_ok && bus.Funct[0] && dp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (flag_upd) begin
      flags[3:2] <= bus.ALUFlags[3:2];
      if (dp_arith) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  always_comb begin
    state_nx       = state;
    pc_w           = 1'b0;
    ir_w           = 1'b0;
    reg_w          = 1'b0;
    mem_w          = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ALUControl = 2'b00;
    bus.ImmSrc     = 2'b00;
    bus.RegSrc     = 2'b00;
    case (state)
      FETCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        ir_w          = bus.mem_ready;
        pc_w          = bus.mem_ready;
        if (bus.mem_ready) state_nx = DECODE;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        case (bus.Op)
          2'b00:   state_nx = bus.Funct[5] ? EXECI : EXECR;
          2'b01:   state_nx = MEMADR;
          2'b10:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      EXECR, EXECI: begin
        bus.ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
        bus.ALUControl = dp_alu;
        state_nx       = ALUWB;
      end
      ALUWB: begin
        reg_w    = cond_ok & dp_wr & ~rd_pc;
        pc_w     = cond_ok & dp_wr & rd_pc;
        state_nx = FETCH;
      end
      MEMADR: begin
        bus.ALUSrcB    = 2'b01;
        bus.ImmSrc     = 2'b01;
        bus.ALUControl = bus.Funct[3] ? 2'b00 : 2'b01;
        state_nx       = bus.Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.AdrSrc = 1'b1;
        if (bus.mem_ready) state_nx = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        reg_w         = cond_ok & ~rd_pc;
        pc_w          = cond_ok & rd_pc;
        state_nx      = FETCH;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.RegSrc = 2'b10;
        mem_w      = cond_ok;
        // a failed condition never touches memory, so it need not wait for ready
        if (bus.mem_ready || !cond_ok) state_nx = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ImmSrc    = 2'b10;
        bus.RegSrc    = 2'b01;
        bus.ResultSrc = 2'b10;
        pc_w          = cond_ok;
        state_nx      = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  assign bus.PCWrite  = pc_w & rst_n;
  assign bus.IRWrite  = ir_w & rst_n;
  assign bus.RegWrite = reg_w & rst_n;
  assign bus.MemWrite = mem_w & rst_n;
  assign bus.Flags    = flags;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed-vector bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sig(input logic pcw, input logic irw, input logic rw, input logic mw,
                                      input logic adr, input logic sa, input logic [1:0] sb,
                                      input logic [1:0] rs, input logic [1:0] ac,
                                      input logic [1:0] imm, input logic [1:0] rsrc);
    return {pcw, irw, rw, mw, adr, sa, sb, rs, ac, imm, rsrc};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc, bus.ALUSrcA,
            bus.ALUSrcB, bus.ResultSrc, bus.ALUControl, bus.ImmSrc, bus.RegSrc};
  endfunction

  task automatic step(input string tag, input logic mr, input logic [15:0] exp);
    bus.mem_ready = mr;
    @(negedge clk);
    check(tag, obs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input logic [3:0] af);
    bus.Cond = c; bus.Op = op; bus.Funct = f; bus.Rd = rd; bus.ALUFlags = af;
  endtask

  logic [15:0] s_fetch, s_idle, s_execi_add, s_execr_sub, s_execr_and, s_execr_cmp;
  logic [15:0] s_wb_reg, s_wb_pc, s_none, s_madr_u, s_madr_d, s_memrd, s_memwb, s_memwr, s_br_t, s_br_f;
  logic [3:0]  cmp_flags;

  initial begin
    s_fetch     = sig(1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    s_idle      = sig(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    s_execi_add = sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    s_execr_sub = sig(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    s_execr_and = sig(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    s_wb_reg    = sig(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    s_wb_pc     = sig(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    s_none      = 16'h0000;
    s_madr_u    = sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
    s_madr_d    = sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00);
    s_memrd     = sig(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    s_memwb     = sig(0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    s_memwr     = sig(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
    s_br_t      = sig(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01);
    s_br_f      = sig(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01);
`ifdef MCFSM_CMP_EN
    s_execr_cmp = sig(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    cmp_flags   = 4'b0100;
`else
    s_execr_cmp = s_execr_sub & 16'hFFCF;
    cmp_flags   = 4'b1010;
`endif

    instr(4'hE, 2'b00, 6'b101000, 4'd3, 4'b1111);
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sig", obs(), s_idle);
    check("reset_flags", {12'd0, bus.Flags}, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD immediate, S=0: flags untouched despite ALUFlags=1111
    step("add_fetch", 1'b1, s_fetch);
    step("add_decode", 1'b1, s_idle);
    step("add_execi", 1'b1, s_execi_add);
    step("add_aluwb", 1'b1, s_wb_reg);
    check("add_flags", {12'd0, bus.Flags}, 16'h0000);

    // LDR with two wait cycles in MEMRD
    instr(4'hE, 2'b01, 6'b011001, 4'd9, 4'b0000);
    step("ldr_fetch", 1'b1, s_fetch);
    step("ldr_decode", 1'b1, s_idle);
    step("ldr_memadr", 1'b1, s_madr_u);
    step("ldr_memrd0", 1'b0, s_memrd);
    step("ldr_memrd1", 1'b0, s_memrd);
    step("ldr_memrd2", 1'b1, s_memrd);
    step("ldr_memwb", 1'b1, s_memwb);

    // STR, U=0
    instr(4'hE, 2'b01, 6'b010000, 4'd2, 4'b0000);
    step("str_fetch", 1'b1, s_fetch);
    step("str_decode", 1'b1, s_idle);
    step("str_memadr", 1'b1, s_madr_d);
    step("str_memwr", 1'b1, s_memwr);

    // SUBS N=1 then BLT taken
    instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b1000);
    step("subs1_fetch", 1'b1, s_fetch);
    step("subs1_decode", 1'b1, s_idle);
    step("subs1_execr", 1'b1, s_execr_sub);
    step("subs1_aluwb", 1'b1, s_wb_reg);
    check("subs1_flags", {12'd0, bus.Flags}, 16'h0008);
    instr(4'hB, 2'b10, 6'b000000, 4'd0, 4'b0000);
    step("blt1_fetch", 1'b1, s_fetch);
    step("blt1_decode", 1'b1, s_idle);
    step("blt1_branch", 1'b1, s_br_t);

    // SUBS N=1 V=1 then BLT not taken
    instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b1001);
    step("subs2_fetch", 1'b1, s_fetch);
    step("subs2_decode", 1'b1, s_idle);
    step("subs2_execr", 1'b1, s_execr_sub);
    step("subs2_aluwb", 1'b1, s_wb_reg);
    check("subs2_flags", {12'd0, bus.Flags}, 16'h0009);
    instr(4'hB, 2'b10, 6'b000000, 4'd0, 4'b0000);
    step("blt2_fetch", 1'b1, s_fetch);
    step("blt2_decode", 1'b1, s_idle);
    step("blt2_branch", 1'b1, s_br_f);

    // ADDEQ with Z=0: no register write
    instr(4'h0, 2'b00, 6'b101000, 4'd4, 4'b0000);
    step("addeq_fetch", 1'b1, s_fetch);
    step("addeq_decode", 1'b1, s_idle);
    step("addeq_execi", 1'b1, s_execi_add);
    step("addeq_aluwb", 1'b1, s_none);

    // ADDS to PC: PCWrite instead of RegWrite, all four flags update
    instr(4'hE, 2'b00, 6'b101001, 4'd15, 4'b0110);
    step("addpc_fetch", 1'b1, s_fetch);
    step("addpc_decode", 1'b1, s_idle);
    step("addpc_execi", 1'b1, s_execi_add);
    step("addpc_aluwb", 1'b1, s_wb_pc);
    check("addpc_flags", {12'd0, bus.Flags}, 16'h0006);

    // ANDS: only N,Z update, C,V keep 10
    instr(4'hE, 2'b00, 6'b000001, 4'd5, 4'b1011);
    step("ands_fetch", 1'b1, s_fetch);
    step("ands_decode", 1'b1, s_idle);
    step("ands_execr", 1'b1, s_execr_and);
    step("ands_aluwb", 1'b1, s_wb_reg);
    check("ands_flags", {12'd0, bus.Flags}, 16'h000A);

    // Op=11: straight back to FETCH after DECODE
    instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);
    step("op3_fetch", 1'b1, s_fetch);
    step("op3_decode", 1'b1, s_idle);

    // CMP
    instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
    step("cmp_fetch", 1'b1, s_fetch);
    step("cmp_decode", 1'b1, s_idle);
    step("cmp_execr", 1'b1, s_execr_cmp);
    step("cmp_aluwb", 1'b1, s_none);
    check("cmp_flags", {12'd0, bus.Flags}, {12'd0, cmp_flags});

    // reset while stalled in MEMWR
    instr(4'hE, 2'b01, 6'b010000, 4'd2, 4'b0000);
    step("rst_fetch", 1'b1, s_fetch);
    step("rst_decode", 1'b1, s_idle);
    step("rst_memadr", 1'b1, s_madr_d);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("rst_memwr", obs(), s_memwr);
    #2 rst_n = 1'b0;
    #1 check("rst_memwrite_drop", {15'd0, bus.MemWrite}, 16'h0000);
    check("rst_sig", obs(), s_idle);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_flags", {12'd0, bus.Flags}, 16'h0000);
    step("post_fetch", 1'b1, s_fetch);
    step("post_decode", 1'b1, s_idle);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
